vscale_htif_pcr_responder: RTL and testbench
============================================

// Module: vscale_htif_pcr_responder
// PURPOSE
//  Core-side responder for the HTIF PCR request/response interface; the host (testbench or fesvr bridge) is the initiator.
//  Holds the TOHOST/FROMHOST mailbox registers.
//  Serves host reads/writes with a valid/ready handshake and exposes both registers to the core CSR file.
//  Sits between the HTIF port of vscale_sim_top and the CSR file.
// PARAMETERS
//  PCR_WIDTH     64      host-side data width (HTIF_PCR_WIDTH)
//  ADDR_WIDTH    12      CSR address width
//  XLEN          32      core-side register width
//  TOHOST_ADDR   12'h780 CSR address of TOHOST (CSR_ADDR_TO_HOST)
//  FROMHOST_ADDR 12'h781 CSR address of FROMHOST
// PORTS
//  clk                 in   1          clock; all logic on posedge
//  reset               in   1          synchronous, active-low (0 = reset)
//  htif_pcr_req_valid  in   1          host request valid
//  htif_pcr_req_ready  out  1          responder can accept a request
//  htif_pcr_req_rw     in   1          1 = write, 0 = read
//  htif_pcr_req_addr   in   ADDR_WIDTH CSR address
//  htif_pcr_req_data   in   PCR_WIDTH  write data
//  htif_pcr_resp_valid out  1          response valid
//  htif_pcr_resp_ready in   1          host accepts response
//  htif_pcr_resp_data  out  PCR_WIDTH  read data / old value on write
//  csr_tohost_wen      in   1          core writes TOHOST this cycle
//  csr_tohost_wdata    in   XLEN       core TOHOST write data
//  csr_fromhost_wen    in   1          core writes FROMHOST (normally 0 to acknowledge)
//  csr_fromhost_wdata  in   XLEN       core FROMHOST write data
//  tohost              out  XLEN       current TOHOST value
//  fromhost            out  XLEN       current FROMHOST value
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE; tohost=0, fromhost=0; resp_valid=0; resp_data=0; req_ready=1.
//   - Reset in RESP discards the pending response.
//  FSM:
//   - IDLE: req_ready=1, resp_valid=0. On req_valid&&req_ready: perform access, latch resp_data, go RESP.
//   - RESP: req_ready=0, resp_valid=1, resp_data held stable. On resp_ready: go IDLE.
//   - Latency: request accepted at edge N -> resp_valid=1 during cycle N+1.
//   - Throughput: at most one request per 2 cycles; no accept in the cycle a response completes.
//  Access rules (accept edge):
//   - Read TOHOST: resp_data = zero-extended tohost; tohost cleared to 0 (read-and-clear, so each core write is seen once).
//   - Read FROMHOST: resp_data = zero-extended fromhost; no side effect.
//   - Write TOHOST/FROMHOST: register <= req_data[XLEN-1:0]; upper bits dropped; resp_data = old value, zero-extended.
//   - Unmapped address: read returns 0; write ignored; still responds.
//  Collisions (same edge):
//   - core tohost write + host TOHOST read/write: resp_data = old value; core write wins, tohost = csr_tohost_wdata.
//   - core fromhost write + host FROMHOST write: host write wins.
//  tohost/fromhost outputs are registers with no combinational path from host inputs.
// TESTING
//  1 reset=0 for 2 cycles -> req_ready=1, resp_valid=0, tohost=0, fromhost=0.
//  2 core writes tohost=1; host reads 0x780 -> resp_valid next cycle with resp_data=1; second read -> 0.
//  3 host writes 0x781 data 64'h1_DEADBEEF -> fromhost=32'hDEADBEEF, resp_data=0.
//  4 hold resp_ready=0 for 3 cycles -> resp_valid stays 1, resp_data stable, req_ready=0; resp_ready=1 -> IDLE.
//  5 tohost=3; core writes 5 on the host read accept edge -> resp_data=3, tohost=5.
//  6 read 0x123 -> resp_data=0; reset=0 while in RESP -> resp_valid=0 next cycle, req_ready=1.

Source files
------------

// File: rtl/vscale_htif_pcr_responder.sv
// ============================================================================
// Module   : vscale_htif_pcr_responder
// Brief    : Core-side HTIF PCR responder holding the TOHOST/FROMHOST mailbox
//            registers, served to the host over a valid/ready request/response
//            handshake and exposed to the core CSR file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vscale_htif_pcr_responder #(
    parameter int                    PCR_WIDTH     = 64,
    parameter int                    ADDR_WIDTH    = 12,
    parameter int                    XLEN          = 32,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR   = 12'h780,
    parameter logic [ADDR_WIDTH-1:0] FROMHOST_ADDR = 12'h781
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  htif_pcr_req_valid,
    output logic                  htif_pcr_req_ready,
    input  logic                  htif_pcr_req_rw,
    input  logic [ADDR_WIDTH-1:0] htif_pcr_req_addr,
    input  logic [PCR_WIDTH-1:0]  htif_pcr_req_data,
    output logic                  htif_pcr_resp_valid,
    input  logic                  htif_pcr_resp_ready,
    output logic [PCR_WIDTH-1:0]  htif_pcr_resp_data,
    input  logic                  csr_tohost_wen,
    input  logic [XLEN-1:0]       csr_tohost_wdata,
    input  logic                  csr_fromhost_wen,
    input  logic [XLEN-1:0]       csr_fromhost_wdata,
    output logic [XLEN-1:0]       tohost,
    output logic [XLEN-1:0]       fromhost
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t                 state_q;
    logic                   req_ready_q;
    logic                   resp_valid_q;
    logic [PCR_WIDTH-1:0]   resp_data_q;
    logic [XLEN-1:0]        tohost_q;
    logic [XLEN-1:0]        fromhost_q;

    logic [XLEN-1:0]        tohost_d;
    logic [XLEN-1:0]        fromhost_d;
    logic [PCR_WIDTH-1:0]   w_old_ext;
    logic                   w_accept;
    logic                   w_hit_to;
    logic                   w_hit_from;

    // Host data above XLEN has nowhere to go; it is intentionally discarded.
    generate
        if (PCR_WIDTH > XLEN) begin : g_upper_drop
            logic w_unused_upper;
            assign w_unused_upper = ^htif_pcr_req_data[PCR_WIDTH-1:XLEN];
        end
    endgenerate

    assign w_accept   = (state_q == S_IDLE) && htif_pcr_req_valid;
    assign w_hit_to   = (htif_pcr_req_addr == TOHOST_ADDR);
    assign w_hit_from = (htif_pcr_req_addr == FROMHOST_ADDR);

    // Response always carries the pre-access value; unmapped addresses read 0.
    always_comb begin
        w_old_ext = '0;
        if (w_hit_to) begin
            w_old_ext[XLEN-1:0] = tohost_q;
        end else if (w_hit_from) begin
            w_old_ext[XLEN-1:0] = fromhost_q;
        end
    end

    // TOHOST: host access first, core write overrides so no core update is lost.
    always_comb begin
        tohost_d = tohost_q;
        if (w_accept && w_hit_to) begin
            tohost_d = htif_pcr_req_rw ? htif_pcr_req_data[XLEN-1:0] : '0;
        end
        if (csr_tohost_wen) begin
            tohost_d = csr_tohost_wdata;
        end
    end

    // FROMHOST: core acknowledge first, a simultaneous host write wins.
    always_comb begin
        fromhost_d = fromhost_q;
        if (csr_fromhost_wen) begin
            fromhost_d = csr_fromhost_wdata;
        end
        if (w_accept && w_hit_from && htif_pcr_req_rw) begin
            fromhost_d = htif_pcr_req_data[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            tohost_q     <= '0;
            fromhost_q   <= '0;
        end else begin
            tohost_q   <= tohost_d;
            fromhost_q <= fromhost_d;
            case (state_q)
                S_IDLE: begin
                    if (htif_pcr_req_valid) begin
                        state_q      <= S_RESP;
                        req_ready_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= w_old_ext;
                    end
                end
                S_RESP: begin
                    // Completion cycle never accepts, capping throughput at 1 per 2.
                    if (htif_pcr_resp_ready) begin
                        state_q      <= S_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign htif_pcr_req_ready  = req_ready_q;
    assign htif_pcr_resp_valid = resp_valid_q;
    assign htif_pcr_resp_data  = resp_data_q;
    assign tohost              = tohost_q;
    assign fromhost            = fromhost_q;

endmodule

`default_nettype wire

// File: tb/tb_vscale_htif_pcr_responder.sv
// ============================================================================
// Module   : tb_vscale_htif_pcr_responder
// Brief    : Directed plus randomized bench for the HTIF PCR responder, checked
//            against a transaction-level mailbox model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vscale_htif_pcr_responder;

    localparam int PW = 64;
    localparam int AW = 12;
    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_rw;
    logic [AW-1:0] req_addr;
    logic [PW-1:0] req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [PW-1:0] resp_data;
    logic          to_wen;
    logic [XL-1:0] to_wdata;
    logic          from_wen;
    logic [XL-1:0] from_wdata;
    logic [XL-1:0] tohost;
    logic [XL-1:0] fromhost;

    int total = 0;
    int bad   = 0;

    // Model: a pending-response flag plus the two mailbox words.
    bit            m_busy;
    logic [XL-1:0] m_to;
    logic [XL-1:0] m_from;
    logic [PW-1:0] m_resp;

    always #5 clk = ~clk;

    vscale_htif_pcr_responder dut (
        .clk                 (clk),
        .reset               (reset),
        .htif_pcr_req_valid  (req_valid),
        .htif_pcr_req_ready  (req_ready),
        .htif_pcr_req_rw     (req_rw),
        .htif_pcr_req_addr   (req_addr),
        .htif_pcr_req_data   (req_data),
        .htif_pcr_resp_valid (resp_valid),
        .htif_pcr_resp_ready (resp_ready),
        .htif_pcr_resp_data  (resp_data),
        .csr_tohost_wen      (to_wen),
        .csr_tohost_wdata    (to_wdata),
        .csr_fromhost_wen    (from_wen),
        .csr_fromhost_wdata  (from_wdata),
        .tohost              (tohost),
        .fromhost            (fromhost)
    );

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("req_ready",  PW'(req_ready),  PW'(!m_busy));
        chk("resp_valid", PW'(resp_valid), PW'(m_busy));
        chk("resp_data",  resp_data,       m_resp);
        chk("tohost",     PW'(tohost),     PW'(m_to));
        chk("fromhost",   PW'(fromhost),   PW'(m_from));
    endtask

    // Apply the mailbox rules for the coming edge, then compare after it.
    task automatic step();
        logic [XL-1:0] old;
        if (!reset) begin
            m_busy = 1'b0;
            m_to   = '0;
            m_from = '0;
            m_resp = '0;
        end else begin
            if (!m_busy && req_valid) begin
                old = (req_addr == 12'h780) ? m_to : (req_addr == 12'h781) ? m_from : '0;
                m_resp = PW'(old);
                if (req_addr == 12'h780) m_to = req_rw ? req_data[XL-1:0] : '0;
                m_busy = 1'b1;
                if (to_wen) m_to = to_wdata;
                if (from_wen) m_from = from_wdata;
                if (req_addr == 12'h781 && req_rw) m_from = req_data[XL-1:0];
            end else begin
                if (m_busy && resp_ready) m_busy = 1'b0;
                if (to_wen) m_to = to_wdata;
                if (from_wen) m_from = from_wdata;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // One full host transaction; returns the response word seen in RESP.
    task automatic host_txn(input logic rw, input logic [AW-1:0] addr,
                            input logic [PW-1:0] data, output logic [PW-1:0] got);
        req_valid  = 1'b1;
        req_rw     = rw;
        req_addr   = addr;
        req_data   = data;
        resp_ready = 1'b0;
        step();
        got        = resp_data;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] got;
        logic [PW-1:0] held;

        reset = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_data = '0;
        resp_ready = 1'b0; to_wen = 1'b0; to_wdata = '0; from_wen = 1'b0; from_wdata = '0;

        // Reset held two cycles.
        step();
        step();
        chk("rst_req_ready",  PW'(req_ready),  64'd1);
        chk("rst_resp_valid", PW'(resp_valid), 64'd0);
        chk("rst_tohost",     PW'(tohost),     64'd0);
        chk("rst_fromhost",   PW'(fromhost),   64'd0);
        reset = 1'b1;
        step();

        // Core posts tohost=1; host reads it once, then sees it cleared.
        to_wen = 1'b1; to_wdata = 32'd1;
        step();
        to_wen = 1'b0;
        host_txn(1'b0, 12'h780, '0, got);
        chk("read_tohost_1", got, 64'd1);
        chk("tohost_cleared", PW'(tohost), 64'd0);
        host_txn(1'b0, 12'h780, '0, got);
        chk("read_tohost_2", got, 64'd0);

        // Host write to FROMHOST drops upper bits, returns old value.
        host_txn(1'b1, 12'h781, 64'h1_DEADBEEF, got);
        chk("wr_from_resp", got, 64'd0);
        chk("wr_from_val",  PW'(fromhost), 64'h0000_0000_DEAD_BEEF);

        // Backpressure: response held stable while resp_ready is low.
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h781; resp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        held = resp_data;
        chk("bp_first", held, 64'h0000_0000_DEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid",  PW'(resp_valid), 64'd1);
            chk("bp_ready",  PW'(req_ready),  64'd0);
            chk("bp_stable", resp_data, held);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("bp_idle", PW'(req_ready), 64'd1);

        // Core write collides with host read of TOHOST.
        to_wen = 1'b1; to_wdata = 32'd3;
        step();
        to_wdata = 32'd5;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h780;
        step();
        to_wen = 1'b0; req_valid = 1'b0;
        chk("coll_resp",   resp_data, 64'd3);
        chk("coll_tohost", PW'(tohost), 64'd5);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Host FROMHOST write beats core acknowledge on the same edge.
        from_wen = 1'b1; from_wdata = 32'd0;
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 12'h781; req_data = 64'h0000_0000_1234_5678;
        step();
        from_wen = 1'b0; req_valid = 1'b0;
        chk("coll_from", PW'(fromhost), 64'h1234_5678);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Unmapped read, then reset while the response is pending.
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h123;
        step();
        req_valid = 1'b0;
        chk("unmapped_resp", resp_data, 64'd0);
        reset = 1'b0;
        step();
        chk("rst_resp_valid2", PW'(resp_valid), 64'd0);
        chk("rst_req_ready2",  PW'(req_ready),  64'd1);
        reset = 1'b1;
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            req_valid  = ($urandom_range(0, 1) == 1);
            req_rw     = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0, 1:    req_addr = 12'h780;
                2:       req_addr = 12'h781;
                default: req_addr = AW'($urandom);
            endcase
            req_data   = {$urandom, $urandom};
            resp_ready = ($urandom_range(0, 9) < 6);
            to_wen     = ($urandom_range(0, 4) == 0);
            to_wdata   = $urandom;
            from_wen   = ($urandom_range(0, 4) == 0);
            from_wdata = $urandom;
            reset      = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
